// File: rtl/dmem_port_arbiter_pkg.sv
// Shared definitions for the data-memory port arbiter: memory sizing,
// requester ownership codes, arbitration states and the address range check.
package dmem_port_arbiter_pkg;

  // Size of Data_Memory in bytes; valid byte addresses are [0, DATA_MEM_SIZE-1].
  localparam int DATA_MEM_SIZE = 1024;

  // Byte-address width seen on both requester ports and on the memory side.
  localparam int DMEM_ADDR_W = 32;

  // Consecutive denied debug cycles tolerated before debug is forced through.
  localparam int DMEM_STARVE_LIMIT = 8;

  // Which requester is owed a read response in the following cycle.
  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_C    = 2'd1,
    OWN_D    = 2'd2
  } owner_e;

  // Arbitration mode.
  typedef enum logic [1:0] {
    ARB_NORMAL  = 2'd0,
    ARB_FORCE_D = 2'd1,
    ARB_LOCKED  = 2'd2
  } arb_state_e;

  // True when a byte address falls inside the memory. Both operands are
  // widened to 64 bits so the full address is compared and a large address
  // can never alias onto a low one.
  function automatic logic addr_in_range(input logic [63:0] addr,
                                         input logic [63:0] mem_bytes);
    return addr < mem_bytes;
  endfunction

endpackage

// File: rtl/dmem_port_arbiter_starve_guard.sv
// Saturating starvation counter for the debug port. It counts cycles in
// which debug asked but was refused, clears on request, and tells the
// arbiter one cycle ahead that the limit will be reached at the next edge.
import dmem_port_arbiter_pkg::*;

module dmem_starve_guard #(
  parameter int LIMIT = DMEM_STARVE_LIMIT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_clr,
  input  logic i_inc,
  output logic o_at_limit,
  output logic o_reach_next
);

  localparam int CW = $clog2(LIMIT + 1);

  logic [CW-1:0] r_cnt;
  logic          w_full;
  logic          w_one_short;

  assign w_full      = (r_cnt == CW'(LIMIT));
  assign w_one_short = (r_cnt == CW'(LIMIT - 1));

  // Count refused debug cycles; clear wins over increment, hold at LIMIT.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_inc && !w_full) begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  assign o_at_limit = w_full;

  // The value after this edge will equal LIMIT: either it already does and
  // nothing clears it, or this cycle's refusal is the one that gets there.
  assign o_reach_next = !i_clr && (w_full || (i_inc && w_one_short));

endmodule

// File: rtl/dmem_port_arbiter.sv
// Two-requester arbiter in front of the single-port Data_Memory.
// Port C (CPU load/store unit) normally has priority; port D (debug/loader)
// is protected from starvation by a forced-grant mode and can hold the
// memory for a burst with i_d_lock. One access is forwarded per cycle and
// the read response is routed back to whichever port issued it.
import dmem_port_arbiter_pkg::*;

module dmem_port_arbiter #(
  parameter int ADDR_W       = DMEM_ADDR_W,
  parameter int MEM_BYTES    = DATA_MEM_SIZE,
  parameter int STARVE_LIMIT = DMEM_STARVE_LIMIT
) (
  input  logic              clk,
  input  logic              rst_n,
  // CPU port
  input  logic              i_c_req,
  input  logic              i_c_we,
  input  logic [ADDR_W-1:0] i_c_addr,
  input  logic [3:0]        i_c_be,
  input  logic [31:0]       i_c_wdata,
  output logic              o_c_gnt,
  output logic              o_c_rvalid,
  output logic [31:0]       o_c_rdata,
  output logic              o_c_rerr,
  // debug / loader port
  input  logic              i_d_req,
  input  logic              i_d_we,
  input  logic [ADDR_W-1:0] i_d_addr,
  input  logic [3:0]        i_d_be,
  input  logic [31:0]       i_d_wdata,
  input  logic              i_d_lock,
  output logic              o_d_gnt,
  output logic              o_d_rvalid,
  output logic [31:0]       o_d_rdata,
  output logic              o_d_rerr,
  // memory side
  output logic              o_mem_en,
  output logic              o_mem_we,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [3:0]        o_mem_be,
  output logic [31:0]       o_mem_wdata,
  input  logic [31:0]       i_mem_rdata
);

  arb_state_e        r_state;
  owner_e            r_owner;
  logic              r_err;

  // Last command presented to memory; replayed while the strobe is low.
  logic              r_mem_we;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [3:0]        r_mem_be;
  logic [31:0]       r_mem_wdata;

  logic              w_normal_rules;
  logic              w_c_acc;
  logic              w_d_acc;
  logic              w_c_inr;
  logic              w_d_inr;
  logic              w_fwd_c;
  logic              w_fwd_d;
  logic              w_starve_clr;
  logic              w_starve_inc;
  logic              w_starve_full;
  logic              w_reach;

  logic              w_cmd_we;
  logic [ADDR_W-1:0] w_cmd_addr;
  logic [3:0]        w_cmd_be;
  logic [31:0]       w_cmd_wdata;

  // ---------------------------------------------------------------------
  // Grant logic
  // ---------------------------------------------------------------------
  // The cycle in which a lock is released already behaves as NORMAL, so the
  // CPU can be granted in the same cycle d_lock falls.
  assign w_normal_rules = (r_state == ARB_NORMAL) ||
                          ((r_state == ARB_LOCKED) && !i_d_lock);

  // Grants are gated with rst_n so that every output reads 0 while in reset.
  assign o_c_gnt = rst_n && i_c_req && w_normal_rules;
  assign o_d_gnt = rst_n && i_d_req && (!w_normal_rules || !i_c_req);

  assign w_c_acc = i_c_req && o_c_gnt;
  assign w_d_acc = i_d_req && o_d_gnt;

  assign w_c_inr = addr_in_range(64'(i_c_addr), 64'(MEM_BYTES));
  assign w_d_inr = addr_in_range(64'(i_d_addr), 64'(MEM_BYTES));

  // ---------------------------------------------------------------------
  // Starvation tracking
  // ---------------------------------------------------------------------
  // A debug acceptance always clears the count; leaving FORCE_D without a
  // grant (request withdrawn) clears it as well.
  assign w_starve_clr = w_d_acc || (r_state == ARB_FORCE_D);
  assign w_starve_inc = i_d_req && !o_d_gnt;

  dmem_starve_guard #(
    .LIMIT (STARVE_LIMIT)
  ) u_starve_guard (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_clr        (w_starve_clr),
    .i_inc        (w_starve_inc),
    .o_at_limit   (w_starve_full),
    .o_reach_next (w_reach)
  );

  // ---------------------------------------------------------------------
  // Arbitration state machine
  // ---------------------------------------------------------------------
  // A locked debug acceptance takes precedence from any state; FORCE_D lasts
  // one cycle (granted or withdrawn); NORMAL-rule cycles move to FORCE_D
  // once the starvation count is about to hit its limit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ARB_NORMAL;
    end else if (w_d_acc && i_d_lock) begin
      r_state <= ARB_LOCKED;
    end else begin
      case (r_state)
        ARB_FORCE_D: begin
          r_state <= ARB_NORMAL;
        end
        ARB_LOCKED: begin
          if (!i_d_lock) begin
            r_state <= w_reach ? ARB_FORCE_D : ARB_NORMAL;
          end
        end
        default: begin
          r_state <= (w_reach || w_starve_full) ? ARB_FORCE_D : ARB_NORMAL;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------
  // Memory forwarding
  // ---------------------------------------------------------------------
  // Only in-range accepted accesses reach memory; out-of-range ones are
  // granted but never strobe the memory.
  assign w_fwd_c = w_c_acc && w_c_inr;
  assign w_fwd_d = w_d_acc && w_d_inr;

  // Select the command presented this cycle, or replay the last one.
  always_comb begin
    w_cmd_we    = r_mem_we;
    w_cmd_addr  = r_mem_addr;
    w_cmd_be    = r_mem_be;
    w_cmd_wdata = r_mem_wdata;
    if (w_fwd_d) begin
      w_cmd_we    = i_d_we;
      w_cmd_addr  = i_d_addr;
      w_cmd_be    = i_d_be;
      w_cmd_wdata = i_d_wdata;
    end else if (w_fwd_c) begin
      w_cmd_we    = i_c_we;
      w_cmd_addr  = i_c_addr;
      w_cmd_be    = i_c_be;
      w_cmd_wdata = i_c_wdata;
    end
  end

  // Remember the command on the memory bus so idle cycles keep it steady.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_be    <= 4'h0;
      r_mem_wdata <= 32'h0;
    end else begin
      r_mem_we    <= w_cmd_we;
      r_mem_addr  <= w_cmd_addr;
      r_mem_be    <= w_cmd_be;
      r_mem_wdata <= w_cmd_wdata;
    end
  end

  assign o_mem_en    = w_fwd_c || w_fwd_d;
  assign o_mem_we    = w_cmd_we;
  assign o_mem_addr  = w_cmd_addr;
  assign o_mem_be    = w_cmd_be;
  assign o_mem_wdata = w_cmd_wdata;

  // ---------------------------------------------------------------------
  // Response routing
  // ---------------------------------------------------------------------
  // Record who issued a read this cycle and whether it was out of range;
  // writes leave no owner, so they never produce a response. An async
  // reset clears the owner and therefore drops a response in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_owner <= OWN_NONE;
      r_err   <= 1'b0;
    end else if (w_c_acc && !i_c_we) begin
      r_owner <= OWN_C;
      r_err   <= !w_c_inr;
    end else if (w_d_acc && !i_d_we) begin
      r_owner <= OWN_D;
      r_err   <= !w_d_inr;
    end else begin
      r_owner <= OWN_NONE;
      r_err   <= 1'b0;
    end
  end

  // Only the owning port sees data; an errored read returns zero.
  assign o_c_rvalid = (r_owner == OWN_C);
  assign o_c_rerr   = (r_owner == OWN_C) && r_err;
  assign o_c_rdata  = ((r_owner == OWN_C) && !r_err) ? i_mem_rdata : 32'h0;

  assign o_d_rvalid = (r_owner == OWN_D);
  assign o_d_rerr   = (r_owner == OWN_D) && r_err;
  assign o_d_rdata  = ((r_owner == OWN_D) && !r_err) ? i_mem_rdata : 32'h0;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Self-checking bench for dmem_port_arbiter: a behavioural memory, a
// per-cycle reference model compared on every falling edge, and directed
// scenarios with hand-computed literal expectations.
module tb_dmem_port_arbiter;

  localparam int MEMB = 1024;
  localparam int LIM  = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        c_req, c_we, d_req, d_we, d_lock;
  logic [31:0] c_addr, d_addr, c_wdata, d_wdata;
  logic [3:0]  c_be, d_be;
  logic        c_gnt, c_rvalid, c_rerr, d_gnt, d_rvalid, d_rerr;
  logic [31:0] c_rdata, d_rdata;
  logic        mem_en, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_be;
  logic [31:0] mem_rdata = 32'h0;

  int checks   = 0;
  int failures = 0;

  dmem_port_arbiter #(
    .ADDR_W       (32),
    .MEM_BYTES    (MEMB),
    .STARVE_LIMIT (LIM)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_c_req     (c_req),
    .i_c_we      (c_we),
    .i_c_addr    (c_addr),
    .i_c_be      (c_be),
    .i_c_wdata   (c_wdata),
    .o_c_gnt     (c_gnt),
    .o_c_rvalid  (c_rvalid),
    .o_c_rdata   (c_rdata),
    .o_c_rerr    (c_rerr),
    .i_d_req     (d_req),
    .i_d_we      (d_we),
    .i_d_addr    (d_addr),
    .i_d_be      (d_be),
    .i_d_wdata   (d_wdata),
    .i_d_lock    (d_lock),
    .o_d_gnt     (d_gnt),
    .o_d_rvalid  (d_rvalid),
    .o_d_rdata   (d_rdata),
    .o_d_rerr    (d_rerr),
    .o_mem_en    (mem_en),
    .o_mem_we    (mem_we),
    .o_mem_addr  (mem_addr),
    .o_mem_be    (mem_be),
    .o_mem_wdata (mem_wdata),
    .i_mem_rdata (mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural Data_Memory ----------------
  logic [31:0] tb_mem [0:255];
  initial for (int i = 0; i < 256; i++) tb_mem[i] = 32'h0;

  always @(posedge clk) begin
    if (mem_en && mem_addr < 32'(MEMB)) begin
      if (mem_we) begin
        for (int b = 0; b < 4; b++)
          if (mem_be[b]) tb_mem[mem_addr[9:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
      end else begin
        mem_rdata <= tb_mem[mem_addr[9:2]];
      end
    end
  end

  // ---------------- reference model ----------------
  logic [31:0] ref_mem [0:255];
  initial for (int i = 0; i < 256; i++) ref_mem[i] = 32'h0;

  int          m_deny = 0;       // refused debug cycles so far
  bit          m_forced = 0;     // debug is owed the next grant
  bit          m_locked = 0;     // debug burst in progress
  int          m_resp = 0;       // 0 none, 1 CPU, 2 debug
  bit          m_err = 0;
  logic [31:0] m_data = 0;
  logic        h_we = 0;
  logic [31:0] h_addr = 0, h_wd = 0;
  logic [3:0]  h_be = 0;

  bit          e_cg, e_dg, normal, acc, inr, p_we, was_forced;
  logic [31:0] p_addr, p_wd;
  logic [3:0]  p_be;

  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_c_gnt", {31'h0, c_gnt}, 0);
      chk("rst_d_gnt", {31'h0, d_gnt}, 0);
      chk("rst_c_rvalid", {31'h0, c_rvalid}, 0);
      chk("rst_d_rvalid", {31'h0, d_rvalid}, 0);
      chk("rst_mem_en", {31'h0, mem_en}, 0);
      chk("rst_mem_addr", mem_addr, 0);
      m_deny = 0; m_forced = 0; m_locked = 0; m_resp = 0; m_err = 0;
      h_we = 0; h_addr = 0; h_wd = 0; h_be = 0;
    end else begin
      // CPU has priority unless debug is owed a turn or holds a live lock.
      normal = !m_forced && !(m_locked && d_lock);
      e_cg = c_req && normal;
      e_dg = d_req && !e_cg;
      chk("c_gnt", {31'h0, c_gnt}, {31'h0, e_cg});
      chk("d_gnt", {31'h0, d_gnt}, {31'h0, e_dg});

      // Response owed from the previous cycle's read.
      chk("c_rvalid", {31'h0, c_rvalid}, {31'h0, m_resp == 1});
      chk("c_rerr", {31'h0, c_rerr}, {31'h0, m_resp == 1 && m_err});
      chk("c_rdata", c_rdata, (m_resp == 1 && !m_err) ? m_data : 32'h0);
      chk("d_rvalid", {31'h0, d_rvalid}, {31'h0, m_resp == 2});
      chk("d_rerr", {31'h0, d_rerr}, {31'h0, m_resp == 2 && m_err});
      chk("d_rdata", d_rdata, (m_resp == 2 && !m_err) ? m_data : 32'h0);

      // Which command, if any, the memory should see.
      acc    = e_cg || e_dg;
      p_we   = e_dg ? d_we : c_we;
      p_addr = e_dg ? d_addr : c_addr;
      p_be   = e_dg ? d_be : c_be;
      p_wd   = e_dg ? d_wdata : c_wdata;
      inr    = p_addr < 32'(MEMB);
      if (acc && inr) begin
        h_we = p_we; h_addr = p_addr; h_be = p_be; h_wd = p_wd;
      end
      chk("mem_en", {31'h0, mem_en}, {31'h0, acc && inr});
      chk("mem_we", {31'h0, mem_we}, {31'h0, h_we});
      chk("mem_addr", mem_addr, h_addr);
      chk("mem_be", {28'h0, mem_be}, {28'h0, h_be});
      chk("mem_wdata", mem_wdata, h_wd);

      // Advance model to the next cycle.
      if (acc && inr && p_we)
        for (int b = 0; b < 4; b++)
          if (p_be[b]) ref_mem[p_addr[9:2]][8*b +: 8] = p_wd[8*b +: 8];
      m_resp = 0; m_err = 0;
      if (acc && !p_we) begin
        m_resp = e_dg ? 2 : 1;
        m_err  = !inr;
        m_data = inr ? ref_mem[p_addr[9:2]] : 32'h0;
      end
      was_forced = m_forced;
      if (e_dg || was_forced) m_deny = 0;
      else if (d_req && m_deny < LIM) m_deny = m_deny + 1;
      if (e_dg && d_lock) begin
        m_locked = 1; m_forced = 0;
      end else if (was_forced) begin
        m_forced = 0; m_locked = 0;
      end else if (m_locked && d_lock) begin
        m_locked = 1;
      end else begin
        m_locked = 0;
        m_forced = (m_deny == LIM);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_dgnt(output int gc);
    gc = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (d_gnt) begin
        gc = i;
        break;
      end
      tick();
    end
  endtask

  int gc;

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 0;
    c_req = 0; c_we = 0; c_addr = 0; c_be = 4'hF; c_wdata = 0;
    d_req = 0; d_we = 0; d_addr = 0; d_be = 4'hF; d_wdata = 0; d_lock = 0;
    repeat (3) tick();
    rst_n = 1;

    // 1. idle after reset
    for (int i = 0; i < 20; i++) begin
      tick();
      @(negedge clk);
      chk("t1_mem_en", {31'h0, mem_en}, 0);
    end
    $display("txn idle x20 done");

    // 2. CPU write then read back
    tick(); c_req = 1; c_we = 1; c_addr = 32'h10; c_wdata = 32'hDEADBEEF;
    @(negedge clk); chk("t2_wr_gnt", {31'h0, c_gnt}, 1);
    $display("txn C write @10 DEADBEEF");
    tick(); c_addr = 32'h20; c_wdata = 32'h0BADF00D;
    $display("txn C write @20 0BADF00D");
    tick(); c_we = 0; c_addr = 32'h10;
    @(negedge clk); chk("t2_rd_gnt", {31'h0, c_gnt}, 1);
    tick(); c_req = 0;
    @(negedge clk);
    chk("t2_rvalid", {31'h0, c_rvalid}, 1);
    chk("t2_rdata", c_rdata, 32'hDEADBEEF);
    chk("t2_d_rvalid", {31'h0, d_rvalid}, 0);
    $display("txn C read @10 -> %h", c_rdata);

    // 3. starvation: CPU hogs the port, debug forced after LIM refusals
    tick(); c_req = 1; c_we = 0; c_addr = 32'h10;
    d_req = 1; d_we = 0; d_addr = 32'h20;
    wait_dgnt(gc);
    chk("t3_grant_cycle", 32'(gc), 9);
    chk("t3_c_gnt_blocked", {31'h0, c_gnt}, 0);
    tick(); d_req = 0;
    @(negedge clk);
    chk("t3_d_rvalid", {31'h0, d_rvalid}, 1);
    chk("t3_d_rdata", d_rdata, 32'h0BADF00D);
    $display("txn D read @20 forced at cycle %0d -> %h", gc, d_rdata);
    tick(); d_req = 1; d_addr = 32'h10;
    wait_dgnt(gc);
    chk("t3_regrant_cycle", 32'(gc), 9);
    tick(); d_req = 0;
    @(negedge clk);
    chk("t3_d_rdata2", d_rdata, 32'hDEADBEEF);
    $display("txn D read @10 forced at cycle %0d -> %h", gc, d_rdata);

    // 4. locked debug burst with CPU still requesting
    tick(); d_req = 1; d_we = 1; d_lock = 1; d_addr = 32'h0; d_wdata = 32'hA5A50000;
    wait_dgnt(gc);
    chk("t4_first_cycle", 32'(gc), 9);
    for (int k = 1; k < 4; k++) begin
      tick(); d_addr = 32'(4 * k); d_wdata = 32'hA5A50000 + 32'(k);
      @(negedge clk);
      chk("t4_d_gnt", {31'h0, d_gnt}, 1);
      chk("t4_c_blocked", {31'h0, c_gnt}, 0);
    end
    tick(); d_req = 0; d_lock = 0;
    @(negedge clk); chk("t4_c_gnt_unlock", {31'h0, c_gnt}, 1);
    $display("txn D locked burst x4 @0..C");
    tick(); c_addr = 32'h8;
    tick(); c_req = 0;
    @(negedge clk); chk("t4_readback", c_rdata, 32'hA5A50002);
    $display("txn C read @8 -> %h", c_rdata);

    // 5. out-of-range accesses
    tick(); c_req = 1; c_we = 0; c_addr = 32'(MEMB);
    @(negedge clk);
    chk("t5_gnt", {31'h0, c_gnt}, 1);
    chk("t5_mem_en", {31'h0, mem_en}, 0);
    tick(); c_req = 0; d_req = 1; d_we = 1; d_addr = 32'hFFFF_FFFC; d_wdata = 32'h12345678;
    @(negedge clk);
    chk("t5_rvalid", {31'h0, c_rvalid}, 1);
    chk("t5_rerr", {31'h0, c_rerr}, 1);
    chk("t5_rdata", c_rdata, 0);
    $display("txn C read @%h -> rerr=%0d", MEMB, c_rerr);
    tick(); d_we = 0; d_addr = 32'(MEMB - 4);
    tick(); d_req = 0; c_req = 1; c_addr = 32'h20;   // D response + C grant coincide
    tick(); c_req = 0; d_req = 1; d_addr = 32'h4;    // C response + D grant coincide
    tick(); d_req = 0;
    @(negedge clk); chk("t5_d_rdata", d_rdata, 32'hA5A50001);
    $display("txn mixed back-to-back done");

    // 6. reset while a debug read response is pending
    tick(); d_req = 1; d_we = 0; d_addr = 32'h10;
    @(negedge clk); chk("t6_gnt", {31'h0, d_gnt}, 1);
    tick(); d_req = 0; rst_n = 0;
    @(negedge clk); chk("t6_dropped", {31'h0, d_rvalid}, 0);
    tick();
    tick(); rst_n = 1;
    @(negedge clk); chk("t6_after", {31'h0, d_rvalid}, 0);
    tick(); c_req = 1; d_req = 1;
    @(negedge clk);
    chk("t6_normal_c", {31'h0, c_gnt}, 1);
    chk("t6_normal_d", {31'h0, d_gnt}, 0);
    $display("txn reset during pending D read");
    tick(); c_req = 0; d_req = 0;
    repeat (3) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
